// File: rtl/pc_select_unit.sv
// Fetch-stage next-PC unit: fetch PC register, sequential/redirect/trap
// selection, imem valid/ready request, redirect buffering and flushes.
module pc_select_unit #(
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int          INSTR_BYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic                  TrapE,
  input  logic                  ImemReady,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  ImemValid,
  output logic                  RedirectPending,
  output logic                  FlushD,
  output logic                  FlushE
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] RV = DATA_WIDTH'(RESET_VECTOR);
  localparam logic [DATA_WIDTH-1:0] TV = DATA_WIDTH'(TRAP_VECTOR);
  localparam logic [DATA_WIDTH-1:0] IB = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] B0 = DATA_WIDTH'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] pend_tgt;
  logic                  pend_trap;

  logic                  adv;
  logic                  ev;
  logic [DATA_WIDTH-1:0] tgt;
  logic                  hold_take;
  logic [DATA_WIDTH-1:0] hold_tgt;
  logic                  hold_trap;

  // Sequential PC wraps modulo 2^DATA_WIDTH.
  assign PCPlus4F = PCF + IB;

  assign adv = ImemValid & ImemReady & ~StallF;
  assign ev  = (state != BOOT) & (TrapE | PCSrcE);

  // Trap wins; branch/jump targets get bit 0 cleared (JALR rule).
  assign tgt = TrapE ? TV : (PCTargetE & ~B0);

  // A trap always replaces the buffer; a branch never displaces a trap.
  assign hold_take = ev & (TrapE | ~pend_trap);
  assign hold_tgt  = hold_take ? tgt : pend_tgt;
  assign hold_trap = hold_take ? TrapE : pend_trap;

  assign FlushD = ev & ~rst;
  assign FlushE = ev & ~rst;

  // Fetch PC, request-valid and redirect-buffer state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BOOT;
      PCF             <= RV;
      ImemValid       <= 1'b0;
      RedirectPending <= 1'b0;
      pend_tgt        <= '0;
      pend_trap       <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state     <= RUN;
          ImemValid <= 1'b1;
        end
        RUN: begin
          if (ev && adv) begin
            PCF <= tgt;
          end else if (ev) begin
            pend_tgt        <= tgt;
            pend_trap       <= TrapE;
            RedirectPending <= 1'b1;
            state           <= HOLD;
          end else if (adv) begin
            PCF <= PCPlus4F;
          end
        end
        HOLD: begin
          if (adv) begin
            PCF             <= hold_tgt;
            pend_tgt        <= '0;
            pend_trap       <= 1'b0;
            RedirectPending <= 1'b0;
            state           <= RUN;
          end else begin
            pend_tgt  <= hold_tgt;
            pend_trap <= hold_trap;
          end
        end
        default: begin
          state           <= BOOT;
          ImemValid       <= 1'b0;
          RedirectPending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_select_unit.sv
// Bench for pc_select_unit: directed test-plan sequences plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_pc_select_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        TrapE;
  logic        ImemReady;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ImemValid;
  logic        RedirectPending;
  logic        FlushD;
  logic        FlushE;

  int total = 0;
  int bad   = 0;

  // model state
  logic        m_known = 1'b0;
  logic        m_boot;
  logic        m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  logic        m_ptrap;

  pc_select_unit dut (
    .clk             (clk),
    .rst             (rst),
    .StallF          (StallF),
    .PCSrcE          (PCSrcE),
    .PCTargetE       (PCTargetE),
    .TrapE           (TrapE),
    .ImemReady       (ImemReady),
    .PCF             (PCF),
    .PCPlus4F        (PCPlus4F),
    .ImemValid       (ImemValid),
    .RedirectPending (RedirectPending),
    .FlushD          (FlushD),
    .FlushE          (FlushE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic s, input logic src,
                      input logic [31:0] t, input logic tr,
                      input logic rd);
    logic        ev;
    logic        adv;
    logic [31:0] nt;
    rst = r; StallF = s; PCSrcE = src;
    PCTargetE = t; TrapE = tr; ImemReady = rd;
    @(negedge clk);
    if (m_known) begin
      ev = !m_boot && (tr || src);
      chk("pcf", PCF, m_pc);
      chk("pcplus4", PCPlus4F, m_pc + 32'd4);
      chk("valid", {31'd0, ImemValid}, {31'd0, !m_boot});
      chk("pending", {31'd0, RedirectPending}, {31'd0, m_hold});
      chk("flushd", {31'd0, FlushD}, {31'd0, ev && !r});
      chk("flushe", {31'd0, FlushE}, {31'd0, ev && !r});
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1;
      m_boot  = 1'b1;
      m_hold  = 1'b0;
      m_pc    = 32'h0;
      m_ptgt  = 32'h0;
      m_ptrap = 1'b0;
    end else if (m_known && m_boot) begin
      m_boot = 1'b0;
    end else if (m_known) begin
      ev  = tr || src;
      adv = rd && !s;
      nt  = tr ? 32'h4 : {t[31:1], 1'b0};
      if (!m_hold) begin
        if (ev && adv) m_pc = nt;
        else if (ev) begin
          m_hold = 1'b1; m_ptgt = nt; m_ptrap = tr;
        end else if (adv) m_pc = m_pc + 32'd4;
      end else begin
        if (ev && (tr || !m_ptrap)) begin
          m_ptgt = nt; m_ptrap = tr;
        end
        if (adv) begin
          m_pc = m_ptgt; m_hold = 1'b0; m_ptrap = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    // reset then sequential run
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("boot_pc", PCF, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("seq4", PCF, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    chk("seq8", PCF, 32'h8);
    // backpressure
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("bp_hold", PCF, 32'h8);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("bp_rel", PCF, 32'hC);
    step(0, 0, 0, 0, 0, 1);
    chk("seq10", PCF, 32'h10);
    // branch redirect, bit 0 cleared
    step(0, 0, 1, 32'h101, 0, 1);
    chk("br_tgt", PCF, 32'h100);
    step(0, 0, 0, 0, 0, 1);
    chk("br_next", PCF, 32'h104);
    // redirect under stall
    step(0, 1, 1, 32'h200, 0, 1);
    chk("st_pc", PCF, 32'h104);
    chk("st_pend", {31'd0, RedirectPending}, 32'd1);
    step(0, 1, 0, 0, 0, 1);
    chk("st_pc2", PCF, 32'h104);
    step(0, 0, 0, 0, 0, 1);
    chk("st_rel", PCF, 32'h200);
    chk("st_clr", {31'd0, RedirectPending}, 32'd0);
    // trap beats branch
    step(0, 0, 1, 32'h300, 1, 1);
    chk("trap_pri", PCF, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    chk("trap_nx", PCF, 32'h8);
    // pending trap not overwritten by branch
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 1, 32'h400, 0, 1);
    chk("ptrap_pc", PCF, 32'h8);
    step(0, 0, 0, 0, 0, 1);
    chk("ptrap_keep", PCF, 32'h4);
    // wrap
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    chk("wrap_pc", PCF, 32'hFFFF_FFFC);
    chk("wrap_p4", PCPlus4F, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_adv", PCF, 32'h0);
    // reset mid-HOLD drops pending redirect
    step(0, 1, 1, 32'h500, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    chk("rst_pc", PCF, 32'h0);
    chk("rst_pend", {31'd0, RedirectPending}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_nostale", PCF, 32'h4);
    // random stimulus
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                      : $urandom;
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           t,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
